// File: rtl/btb_assoc_if.sv
// Lookup (IF stage) and update (EX stage) signal bundle for btb_assoc.
// The master drives PC_in and the update/flush fields; the slave (the BTB) drives the lookup result.
interface btb_assoc_if #(
    parameter int WAYS     = 2,
    parameter int TARGET_W = 33
);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [31:0]         PC_in;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [TARGET_W-1:0] target_addr;
    logic                predict_taken;

    // Update handshake: upd_valid qualifies upd_pc/upd_taken/upd_target for one cycle.
    // There is no ready; the BTB accepts every valid update unless rst or flush is high that cycle.
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic                upd_taken;
    logic [TARGET_W-1:0] upd_target;
    logic                flush;

    modport master (
        output PC_in, upd_valid, upd_pc, upd_taken, upd_target, flush,
        input  hit, hit_way, target_addr, predict_taken
    );

    modport slave (
        input  PC_in, upd_valid, upd_pc, upd_taken, upd_target, flush,
        output hit, hit_way, target_addr, predict_taken
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB with 2-bit direction counters and per-set round-robin replacement.
// Optional macro BTB_STATS_EN adds stat_updates/stat_allocs/stat_evicts counters.
module btb_assoc #(
    parameter int ENTRIES  = 128,
    parameter int WAYS     = 2,
    parameter int TARGET_W = 33
) (
    input logic        clk,
    input logic        rst,
    btb_assoc_if.slave bus
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_allocs,
    output logic [31:0] stat_evicts
`endif
);
    localparam int SETS   = ENTRIES / WAYS;
    localparam int IDX_W  = $clog2(SETS);
    localparam int IDX_WL = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W  = 30 - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ENT_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [ENTRIES];
    logic [TAG_W-1:0]    tag_d [ENTRIES];
    logic [TARGET_W-1:0] tgt_q [ENTRIES];
    logic [TARGET_W-1:0] tgt_d [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];
    logic [1:0]          ctr_d [ENTRIES];
    logic [WAY_W-1:0]    vic_q [SETS];
    logic [WAY_W-1:0]    vic_d [SETS];

    function automatic logic [IDX_WL-1:0] idx_of(input logic [31:0] pc);
        if (SETS > 1) return IDX_WL'(pc[31:2]);
        return '0;
    endfunction

    function automatic logic [ENT_W-1:0] ent(input logic [IDX_WL-1:0] idx, input int w);
        return ENT_W'(int'(idx) * WAYS + w);
    endfunction

    // Lookup: all ways compared in parallel, lowest matching way wins.
    logic [IDX_WL-1:0] lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [WAYS-1:0]   lk_match;

    always_comb begin
        lk_idx            = idx_of(bus.PC_in);
        lk_tag            = bus.PC_in[31:IDX_W+2];
        lk_match          = '0;
        bus.hit_way       = '0;
        bus.target_addr   = '0;
        bus.predict_taken = 1'b0;
        for (int w = 0; w < WAYS; w++)
            lk_match[w] = valid_q[ent(lk_idx, w)] && (tag_q[ent(lk_idx, w)] == lk_tag);
        bus.hit = |lk_match;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_match[w]) begin
                bus.hit_way       = WAY_W'(w);
                bus.target_addr   = tgt_q[ent(lk_idx, w)];
                bus.predict_taken = ctr_q[ent(lk_idx, w)][1];
            end
        end
    end

    // Update path: train on a hit, allocate on a taken miss.
    logic [IDX_WL-1:0] up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic [WAYS-1:0]   up_match;
    logic [WAYS-1:0]   up_inv;
    logic [WAY_W-1:0]  up_way;
    logic [WAY_W-1:0]  free_way;
    logic [WAY_W-1:0]  victim;
    logic [ENT_W-1:0]  up_e;
    logic              do_upd, do_alloc, do_evict;

    always_comb begin
        up_idx   = idx_of(bus.upd_pc);
        up_tag   = bus.upd_pc[31:IDX_W+2];
        up_match = '0;
        up_inv   = '0;
        up_way   = '0;
        free_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            up_match[w] = valid_q[ent(up_idx, w)] && (tag_q[ent(up_idx, w)] == up_tag);
            up_inv[w]   = !valid_q[ent(up_idx, w)];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (up_match[w]) up_way = WAY_W'(w);
            if (up_inv[w])   free_way = WAY_W'(w);
        end
        do_upd   = bus.upd_valid && !bus.flush;
        do_alloc = do_upd && !(|up_match) && bus.upd_taken;
        do_evict = do_alloc && !(|up_inv);
        victim   = (|up_inv) ? free_way : vic_q[up_idx];
        up_e     = (|up_match) ? ent(up_idx, int'(up_way)) : ent(up_idx, int'(victim));

        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        vic_d   = vic_q;
        if (bus.flush) begin
            valid_d = '0;
            for (int s = 0; s < SETS; s++) vic_d[s] = '0;
        end else if (do_upd && (|up_match)) begin
            if (bus.upd_taken) begin
                if (ctr_q[up_e] != 2'b11) ctr_d[up_e] = ctr_q[up_e] + 2'd1;
                tgt_d[up_e] = bus.upd_target;
            end else if (ctr_q[up_e] != 2'b00) begin
                ctr_d[up_e] = ctr_q[up_e] - 2'd1;
            end
        end else if (do_alloc) begin
            valid_d[up_e] = 1'b1;
            tag_d[up_e]   = up_tag;
            tgt_d[up_e]   = bus.upd_target;
            ctr_d[up_e]   = 2'b10;
            if (do_evict) vic_d[up_idx] = WAY_W'((int'(victim) + 1) % WAYS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                tag_q[e] <= '0;
                tgt_q[e] <= '0;
                ctr_q[e] <= '0;
            end
            for (int s = 0; s < SETS; s++) vic_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
            vic_q   <= vic_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_updates_q, stat_updates_d;
    logic [31:0] stat_allocs_q, stat_allocs_d;
    logic [31:0] stat_evicts_q, stat_evicts_d;

    always_comb begin
        stat_updates_d = stat_updates_q + {31'd0, do_upd};
        stat_allocs_d  = stat_allocs_q + {31'd0, do_alloc};
        stat_evicts_d  = stat_evicts_q + {31'd0, do_evict};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_updates_q <= '0;
            stat_allocs_q  <= '0;
            stat_evicts_q  <= '0;
        end else begin
            stat_updates_q <= stat_updates_d;
            stat_allocs_q  <= stat_allocs_d;
            stat_evicts_q  <= stat_evicts_d;
        end
    end

    assign stat_updates = stat_updates_q;
    assign stat_allocs  = stat_allocs_q;
    assign stat_evicts  = stat_evicts_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert ($countones(lk_match) <= 1)
            else $error("btb_assoc: multiple ways hit in set %0d", lk_idx);
        end
    end
`endif
endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc (ENTRIES=8, WAYS=2): directed cases plus random traffic against a set/way model.
module tb_btb_assoc;
    localparam int ENTRIES  = 8;
    localparam int WAYS     = 2;
    localparam int TARGET_W = 33;
    localparam int SETS     = ENTRIES / WAYS;
    localparam int WAY_W    = 1;
    localparam int W        = 1 + WAY_W + TARGET_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_assoc_if #(.WAYS(WAYS), .TARGET_W(TARGET_W)) bus ();

`ifdef BTB_STATS_EN
    logic [31:0] stat_updates, stat_allocs, stat_evicts;
`endif

    btb_assoc #(.ENTRIES(ENTRIES), .WAYS(WAYS), .TARGET_W(TARGET_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BTB_STATS_EN
        ,
        .stat_updates (stat_updates),
        .stat_allocs  (stat_allocs),
        .stat_evicts  (stat_evicts)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each set holds WAYS slots keyed by the full word address.
    bit                  m_valid [SETS][WAYS];
    logic [29:0]         m_key   [SETS][WAYS];
    logic [TARGET_W-1:0] m_tgt   [SETS][WAYS];
    int                  m_ctr   [SETS][WAYS];
    int                  m_vic   [SETS];
    logic [31:0]         m_upd, m_alloc, m_evict;

    logic [W-1:0] exp_q [$];
    logic [31:0]  exp_pc_q [$];
    logic         look_v = 1'b0;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_vic[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_key[s][w]   = '0;
                m_tgt[s][w]   = '0;
                m_ctr[s][w]   = 0;
            end
        end
        m_upd = 0; m_alloc = 0; m_evict = 0;
    endtask

    function automatic logic [W-1:0] model_look(input logic [31:0] pc);
        int s = int'(pc[31:2] % SETS);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_key[s][w] == pc[31:2])
                return {1'b1, WAY_W'(w), m_tgt[s][w], (m_ctr[s][w] >= 2)};
        return '0;
    endfunction

    task automatic model_update(input logic [31:0] pc, input bit taken, input logic [TARGET_W-1:0] tgt);
        int s = int'(pc[31:2] % SETS);
        int hw = -1;
        int v = -1;
        bit evict = 1'b0;
        m_upd++;
        for (int w = 0; w < WAYS; w++)
            if (hw < 0 && m_valid[s][w] && m_key[s][w] == pc[31:2]) hw = w;
        if (hw >= 0) begin
            if (taken) begin
                m_ctr[s][hw] = (m_ctr[s][hw] == 3) ? 3 : m_ctr[s][hw] + 1;
                m_tgt[s][hw] = tgt;
            end else begin
                m_ctr[s][hw] = (m_ctr[s][hw] == 0) ? 0 : m_ctr[s][hw] - 1;
            end
        end else if (taken) begin
            for (int w = 0; w < WAYS; w++)
                if (v < 0 && !m_valid[s][w]) v = w;
            if (v < 0) begin
                v = m_vic[s];
                evict = 1'b1;
                m_vic[s] = (v + 1) % WAYS;
            end
            m_valid[s][v] = 1'b1;
            m_key[s][v]   = pc[31:2];
            m_tgt[s][v]   = tgt;
            m_ctr[s][v]   = 2;
            m_alloc++;
            if (evict) m_evict++;
        end
    endtask

    // Driver: called at posedge+1; drives one cycle, queues the pre-update lookup result, then advances the model.
    task automatic do_cycle(input logic [31:0] lk, input bit uv, input logic [31:0] upc, input bit ut,
                            input logic [TARGET_W-1:0] utgt, input bit fl, input bit r);
        bus.PC_in      = lk;
        bus.upd_valid  = uv;
        bus.upd_pc     = upc;
        bus.upd_taken  = ut;
        bus.upd_target = utgt;
        bus.flush      = fl;
        rst            = r;
        exp_q.push_back(model_look(lk));
        exp_pc_q.push_back(lk);
        look_v = 1'b1;
        if (r) model_reset();
        else if (fl) begin
            for (int s = 0; s < SETS; s++) begin
                m_vic[s] = 0;
                for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
            end
        end else if (uv) model_update(upc, ut, utgt);
        @(posedge clk);
        #1;
        look_v = 1'b0;
`ifdef BTB_STATS_EN
        n_checks++;
        if ({stat_updates, stat_allocs, stat_evicts} !== {m_upd, m_alloc, m_evict}) begin
            n_fail++;
            $display("FAIL stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", stat_updates, stat_allocs, stat_evicts,
                     m_upd, m_alloc, m_evict);
        end
`endif
    endtask

    task automatic look(input logic [31:0] pc);
        do_cycle(pc, 1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] lk, input logic [31:0] pc, input bit t, input logic [TARGET_W-1:0] tgt);
        do_cycle(lk, 1'b1, pc, t, tgt, 1'b0, 1'b0);
    endtask

    // Monitor: pops one expectation per driven lookup and compares mid-cycle.
    always @(negedge clk) begin
        if (look_v) begin
            logic [W-1:0]  exp_v;
            logic [W-1:0]  act_v;
            logic [31:0]   pc_v;
            n_checks++;
            act_v = {bus.hit, bus.hit_way, bus.target_addr, bus.predict_taken};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL lookup_underflow got=%h", act_v);
            end else begin
                exp_v = exp_q.pop_front();
                pc_v  = exp_pc_q.pop_front();
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL lookup pc=%h got hit=%b way=%0d tgt=%h pt=%b exp hit=%b way=%0d tgt=%h pt=%b",
                             pc_v, act_v[W-1], act_v[W-2], act_v[TARGET_W:1], act_v[0],
                             exp_v[W-1], exp_v[W-2], exp_v[TARGET_W:1], exp_v[0]);
                end
            end
        end
    end

    function automatic logic [31:0] rand_pc();
        logic [1:0] hi = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
        return {hi, 23'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        bus.PC_in = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
        bus.upd_target = '0; bus.flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and first allocation
        look(32'h100);
        upd(32'h0, 32'h100, 1'b1, 33'h200);
        look(32'h100);
        // Same-set aliasing and round-robin eviction
        upd(32'h0, 32'h110, 1'b1, 33'h1_0000_0110);
        upd(32'h0, 32'h120, 1'b1, 33'h120);
        look(32'h100);
        look(32'h110);
        look(32'h120);
        // Re-allocate 0x100 then walk the counter through both saturation points
        upd(32'h100, 32'h100, 1'b1, 33'h300);
        for (int i = 0; i < 3; i++) begin
            upd(32'h100, 32'h100, 1'b0, 33'h0);
            look(32'h100);
        end
        for (int i = 0; i < 4; i++) begin
            upd(32'h100, 32'h100, 1'b1, 33'(32'h400 + i));
            look(32'h100);
        end
        // Flush beats a same-cycle update; victim pointers restart at way 0
        do_cycle(32'h100, 1'b1, 32'h140, 1'b1, 33'h140, 1'b1, 1'b0);
        look(32'h100);
        look(32'h140);
        upd(32'h0, 32'h100, 1'b1, 33'h11);
        upd(32'h0, 32'h110, 1'b1, 33'h22);
        upd(32'h0, 32'h120, 1'b1, 33'h33);
        look(32'h100);
        look(32'h110);
        // Same-cycle lookup and update: old contents now, new contents next cycle
        upd(32'h104, 32'h104, 1'b1, 33'h104);
        look(32'h104);
        look(32'h107);
        // Reset wins over a same-cycle update
        do_cycle(32'h110, 1'b1, 32'h130, 1'b1, 33'h5, 1'b1, 1'b1);
        look(32'h110);
        look(32'h130);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] lk = rand_pc();
            logic [31:0] up = ($urandom_range(0, 1) == 1) ? lk : rand_pc();
            do_cycle(lk, $urandom_range(0, 3) != 0, up, $urandom_range(0, 2) != 0,
                     {1'($urandom_range(0, 1)), 32'($urandom)},
                     $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
        end

        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Set-associative Branch Target Buffer with per-entry 2-bit direction counters; successor of the direct-mapped BTB in the IF stage.
- Combinational lookup on the fetch PC returns hit, way, target and a taken prediction.
- Synchronous update from the resolving EX stage trains counters, allocates entries and replaces them round-robin per set.
- Global flush input invalidates all entries, e.g. on fence.i.

Parameters:
- ENTRIES, 128: total entries; power of two, >= WAYS.
- WAYS, 2: associativity; power of two, 1..8.
- TARGET_W, 33: width of the stored target word, kept opaque.
- Derived: SETS=ENTRIES/WAYS; IDX_W=$clog2(SETS); TAG_W=30-IDX_W; WAY_W=max(1,$clog2(WAYS)).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- PC_in  in  32  fetch PC to look up.
- hit  out  1  valid entry with matching tag found in the indexed set.
- hit_way  out  WAY_W  way that hit; 0 when no hit.
- target_addr  out  TARGET_W  stored target on hit, else 0.
- predict_taken  out  1  hit && counter[1].
- upd_valid  in  1  update request this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  TARGET_W  resolved target; written only when taken.
- flush  in  1  invalidate all entries.

Behaviour:
- Addressing: index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2]. PC[1:0] is ignored. The same mapping applies to upd_pc.
- Per-entry state: valid, tag, target, 2-bit saturating counter. Per-set state: victim pointer of WAY_W bits.
- Lookup is purely combinational with zero latency.
  - All ways of the set are compared in parallel.
  - At most one way can match; the update rule below guarantees this.
  - Lowest-index match wins as a defensive priority.
- Reset (rst=1 at a clock edge) clears all valid bits, tags, targets, counters and victim pointers.
  - After reset: hit=0, hit_way=0, target_addr=0, predict_taken=0.
  - rst has priority over flush and upd_valid.
- Flush (flush=1, rst=0) clears all valid bits and victim pointers in one cycle.
  - Tags, targets and counters may be left stale.
  - Flush has priority over a same-cycle update; that update is dropped.
- Update (upd_valid=1, no rst, no flush). Tag-compare the upd_pc set first.
  - Update hit in way w, taken: counter = min(counter+1, 3); target <= upd_target.
  - Update hit in way w, not taken: counter = max(counter-1, 0); target unchanged; entry stays valid.
  - Update miss, not taken: no change, no allocation.
  - Update miss, taken: allocate.
    - Victim is the lowest-index invalid way if one exists; otherwise the way at the victim pointer.
    - Write valid=1, tag, target, counter=2'b10 (weakly taken).
    - Victim pointer <= (victim+1) mod WAYS only when a valid entry was evicted.
- Same-cycle lookup and update to the same set: lookup returns pre-update contents. The written value is visible from the next cycle.
- WAYS=1 degenerates to direct-mapped: hit_way is always 0 and every miss-taken allocation overwrites.
- Simulation-only assertion: more than one way hits in a set → error.

Optional Feature:
- Macro BTB_STATS_EN. When defined, three extra output ports are added:
  - stat_updates: counts accepted updates.
  - stat_allocs: counts allocations.
  - stat_evicts: counts allocations that replaced a valid entry.
- All three are 32-bit and wrap at 2^32.
- They are cleared only by rst; flush does not clear them.
- A dropped update (flush same cycle) is not counted.
- When not defined, the ports and counters do not exist and functional behaviour is identical.

Test Plan (ENTRIES=8, WAYS=2 → 4 sets, index PC[3:2]):
1. Reset, then lookup PC_in=0x100 → hit=0, target_addr=0, predict_taken=0.
2. Update upd_pc=0x100, taken, target=0x200; next cycle PC_in=0x100 → hit=1, hit_way=0, target_addr=0x200, predict_taken=1 (ctr=2).
3. Same-set aliasing and eviction:
   - Taken updates to 0x100, 0x110, 0x120 (all set 0) → 0x100 in way0, 0x110 in way1.
   - 0x120 evicts way0 (pointer 0→1); lookup 0x100 → hit=0; lookup 0x110 → hit=1, hit_way=1.
4. Counter training on 0x100 (ctr=2):
   - Two not-taken updates → ctr=0, hit=1, predict_taken=0.
   - A third not-taken update keeps ctr=0.
   - Three taken updates → ctr=3; a fourth keeps ctr=3.
5. Allocate 0x100 and flush in the same cycle as a taken update to 0x140 → next cycle both miss, and the pointer for set 0 is 0.
6. Same-cycle lookup and update of 0x104 → hit=0 in that cycle, hit=1 the next. With BTB_STATS_EN, sequence 3 gives stat_updates=3, stat_allocs=3, stat_evicts=1.
